// File: rtl/inst_issue_queue.sv
// Instruction queue between IF and ID: circular {pc,inst} store, multi-entry push/pop, flush.
// Optional macro IQ_BYPASS_EN forwards pushed words straight to issue_* while the queue is empty.
module inst_issue_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             push_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0] push_count,
  input  logic [31:0]                      push_pc,
  input  logic [FETCH_WIDTH*32-1:0]        push_inst,
  output logic                             push_ready,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0] pop_count,
  output logic [ISSUE_WIDTH-1:0]           issue_valid,
  output logic [ISSUE_WIDTH*32-1:0]        issue_inst,
  output logic [ISSUE_WIDTH*32-1:0]        issue_pc,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             empty,
  output logic                             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][31:0] mem_pc;
  logic [DEPTH-1:0][31:0] mem_inst;
  logic [AW-1:0]          head;
  logic [AW-1:0]          tail;
  logic                   push_fire;
  logic                   bypass_act;
  int                     push_n;
  int                     pop_n;
  int                     skip_n;

  // Ready looks only at the registered count, so a same-cycle pop never feeds back into IF.
  assign push_ready = (CW'(DEPTH) - count) >= CW'(FETCH_WIDTH);
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign push_fire  = push_valid & push_ready & ~flush;

`ifdef IQ_BYPASS_EN
  assign bypass_act = (count == '0) && push_fire && (push_count != '0);
`else
  assign bypass_act = 1'b0;
`endif

  // In bypass the first pop_count pushed words are consumed directly and never stored.
  always_comb begin
    push_n = push_fire ? 32'(push_count) : 0;
    pop_n  = flush ? 0 : 32'(pop_count);
    skip_n = bypass_act ? pop_n : 0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + AW'(push_n - skip_n);
      head  <= bypass_act ? head : head + AW'(pop_n);
      count <= CW'(32'(count) + 32'(push_n) - 32'(pop_n));
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic        we;
    logic [31:0] wpc;
    logic [31:0] winst;

    always_comb begin
      we    = 1'b0;
      wpc   = '0;
      winst = '0;
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (j >= skip_n && j < push_n && (tail + AW'(j - skip_n)) == AW'(e)) begin
          we    = 1'b1;
          wpc   = push_pc + 32'(4 * j);
          winst = push_inst[32*j +: 32];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (we) begin
        mem_pc[e]   <= wpc;
        mem_inst[e] <= winst;
      end
    end
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_issue
    logic [AW-1:0] rd_idx;
    logic          fifo_hit;
    logic          byp_hit;
    logic [31:0]   byp_pc;
    logic [31:0]   byp_inst;

    assign rd_idx   = head + AW'(i);
    assign fifo_hit = count > CW'(i);

    if (i < FETCH_WIDTH) begin : g_byp
      assign byp_hit  = bypass_act && (push_n > i);
      assign byp_pc   = push_pc + 32'(4 * i);
      assign byp_inst = push_inst[32*i +: 32];
    end else begin : g_nobyp
      assign byp_hit  = 1'b0;
      assign byp_pc   = '0;
      assign byp_inst = '0;
    end

    assign issue_valid[i]       = byp_hit | fifo_hit;
    assign issue_pc[32*i +: 32]   = byp_hit ? byp_pc   : (fifo_hit ? mem_pc[rd_idx]   : 32'h0);
    assign issue_inst[32*i +: 32] = byp_hit ? byp_inst : (fifo_hit ? mem_inst[rd_idx] : 32'h0);
  end

  // Illegal-input guards; flush discards the cycle's push and pop so it is exempt.
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      assert (!push_valid || 32'(push_count) <= 32'(FETCH_WIDTH))
        else $error("push_count exceeds FETCH_WIDTH");
      assert (32'(pop_count) <= 32'($countones(issue_valid)))
        else $error("pop_count exceeds valid issue slots");
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Self-checking bench for inst_issue_queue: queue-based reference model compared every cycle,
// plus hand-computed literal checks; follows IQ_BYPASS_EN when that macro is defined.
module tb_inst_issue_queue;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic [1:0]  push_count;
  logic [31:0] push_pc;
  logic [63:0] push_inst;
  logic        push_ready;
  logic [1:0]  pop_count;
  logic [1:0]  issue_valid;
  logic [63:0] issue_inst;
  logic [63:0] issue_pc;
  logic [4:0]  count;
  logic        empty;
  logic        full;

  int          n_compared;
  int          n_mismatched;
  logic        cmp_en;
  entry_t      model_q[$];
  logic [31:0] next_pc;

  inst_issue_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_count(push_count), .push_pc(push_pc), .push_inst(push_inst),
    .push_ready(push_ready), .pop_count(pop_count),
    .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_pc(issue_pc),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic pv, input int pcnt, input logic [31:0] pc,
                               input logic [63:0] inst, input int popc, input logic fl);
    @(posedge clk);
    #1;
    push_valid = pv;
    push_count = pcnt[1:0];
    push_pc    = pc;
    push_inst  = inst;
    pop_count  = popc[1:0];
    flush      = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 32'h0, 64'h0, 0, 1'b0);
  endtask

  task automatic pushSeq(input int n, input int popc);
    applyStimulus(1'b1, n, next_pc, {mk_inst(next_pc + 32'd4), mk_inst(next_pc)}, popc, 1'b0);
    next_pc = next_pc + 32'(4 * n);
  endtask

  // Reference model: a plain FIFO of entries; push accepted words, then pop from the front.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      if (push_valid && (DEPTH - model_q.size()) >= FW) begin
        for (int k = 0; k < 32'(push_count); k++) begin
          model_q.push_back('{pc: push_pc + 32'(4 * k), inst: push_inst[32*k +: 32]});
        end
      end
      for (int k = 0; k < 32'(pop_count); k++) begin
        if (model_q.size() > 0) void'(model_q.pop_front());
      end
    end
  end

  // Every cycle, the oldest visible entries must appear in slot order; empty slots read as zero.
  always @(negedge clk) begin
    entry_t      view[$];
    logic [1:0]  exp_valid;
    logic [63:0] exp_inst;
    logic [63:0] exp_pc;
    if (cmp_en) begin
      view = model_q;
`ifdef IQ_BYPASS_EN
      if (model_q.size() == 0 && rst && !flush && push_valid && push_count != 2'd0) begin
        for (int k = 0; k < 32'(push_count); k++) begin
          view.push_back('{pc: push_pc + 32'(4 * k), inst: push_inst[32*k +: 32]});
        end
      end
`endif
      exp_valid = '0;
      exp_inst  = '0;
      exp_pc    = '0;
      for (int k = 0; k < IW; k++) begin
        if (k < view.size()) begin
          exp_valid[k]       = 1'b1;
          exp_inst[32*k +: 32] = view[k].inst;
          exp_pc[32*k +: 32]   = view[k].pc;
        end
      end
      checkOutput("issue_valid", 64'(issue_valid), 64'(exp_valid));
      checkOutput("issue_inst", issue_inst, exp_inst);
      checkOutput("issue_pc", issue_pc, exp_pc);
      checkOutput("count", 64'(count), 64'(model_q.size()));
      checkOutput("empty", 64'(empty), 64'(model_q.size() == 0));
      checkOutput("full", 64'(full), 64'(model_q.size() == DEPTH));
      checkOutput("push_ready", 64'(push_ready), 64'((DEPTH - model_q.size()) >= FW));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b0;
    flush        = 1'b0;
    push_valid   = 1'b0;
    push_count   = '0;
    push_pc      = '0;
    push_inst    = '0;
    pop_count    = '0;
    cmp_en       = 1'b1;
    next_pc      = 32'h0000_0100;
    #12 rst = 1'b1;

    // Asynchronous reset with five entries in flight.
    pushSeq(2, 0);
    pushSeq(2, 0);
    pushSeq(1, 0);
    idle();
    #2;
    checkOutput("pre_reset_count", 64'(count), 64'd5);
    rst = 1'b0;
    #1;
    checkOutput("rst_issue_valid", 64'(issue_valid), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_push_ready", 64'(push_ready), 64'd1);
    checkOutput("rst_full", 64'(full), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // First-push latency and slot PC ordering.
    applyStimulus(1'b1, 2, 32'h8000_0000, {32'hBBBB_0002, 32'hAAAA_0001}, 0, 1'b0);
    idle();
    #2;
    checkOutput("t2_valid", 64'(issue_valid), 64'h3);
    checkOutput("t2_pc", issue_pc, {32'h8000_0004, 32'h8000_0000});
    checkOutput("t2_inst", issue_inst, {32'hBBBB_0002, 32'hAAAA_0001});
    checkOutput("t2_count", 64'(count), 64'd2);
    applyStimulus(1'b0, 0, 32'h0, 64'h0, 2, 1'b0);

    // Fill to full, including pushes refused while not ready.
    next_pc = 32'h0000_2000;
    for (int k = 0; k < 7; k++) pushSeq(2, 0);
    idle();
    #2;
    checkOutput("t3_count14", 64'(count), 64'd14);
    checkOutput("t3_ready14", 64'(push_ready), 64'd1);
    pushSeq(1, 0);
    idle();
    #2;
    checkOutput("t3_count15", 64'(count), 64'd15);
    checkOutput("t3_ready15", 64'(push_ready), 64'd0);
    checkOutput("t3_full15", 64'(full), 64'd0);
    applyStimulus(1'b1, 2, 32'hBAD0_0000, 64'hBAD1_BAD1_BAD0_BAD0, 0, 1'b0);
    idle();
    #2;
    checkOutput("t3_refused15", 64'(count), 64'd15);
    applyStimulus(1'b0, 0, 32'h0, 64'h0, 1, 1'b0);
    pushSeq(2, 0);
    idle();
    #2;
    checkOutput("t3_count16", 64'(count), 64'd16);
    checkOutput("t3_full16", 64'(full), 64'd1);
    checkOutput("t3_ready16", 64'(push_ready), 64'd0);
    applyStimulus(1'b1, 2, 32'hBAD0_0000, 64'hBAD1_BAD1_BAD0_BAD0, 0, 1'b0);
    idle();
    #2;
    checkOutput("t3_refused16", 64'(count), 64'd16);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 0, 32'h0, 64'h0, 2, 1'b0);
    idle();
    #2;
    checkOutput("t3_drained", 64'(empty), 64'd1);

    // Walk head to entry 15 so the two visible entries straddle the wrap.
    applyStimulus(1'b0, 0, 32'h0, 64'h0, 0, 1'b1);
    next_pc = 32'h0000_1000;
    pushSeq(1, 0);
    for (int k = 0; k < 14; k++) pushSeq(1, 1);
    pushSeq(2, 1);
    idle();
    #2;
    checkOutput("t4_count", 64'(count), 64'd2);
    checkOutput("t4_slot0_pc", 64'(issue_pc[31:0]), 64'h103C);
    checkOutput("t4_slot1_pc", 64'(issue_pc[63:32]), 64'h1040);
    checkOutput("t4_slot0_inst", 64'(issue_inst[31:0]), 64'(32'h0000_103C ^ 32'hC0DE_0000));

    // Flush beats a simultaneous push and pop.
    pushSeq(2, 0);
    pushSeq(2, 0);
    idle();
    #2;
    checkOutput("t5_count6", 64'(count), 64'd6);
    applyStimulus(1'b1, 2, 32'hDEAD_0000, 64'hDEAD_0004_DEAD_0000, 2, 1'b1);
    idle();
    #2;
    checkOutput("t5_count", 64'(count), 64'd0);
    checkOutput("t5_empty", 64'(empty), 64'd1);
    checkOutput("t5_valid", 64'(issue_valid), 64'd0);
    idle();

    // Push into an empty queue: same-cycle forward with bypass, one-cycle latency without.
`ifdef IQ_BYPASS_EN
    applyStimulus(1'b1, 2, 32'h0000_3000, {32'hBBBB_0002, 32'hAAAA_0001}, 1, 1'b0);
    #2;
    checkOutput("t6_byp_valid", 64'(issue_valid), 64'h3);
    checkOutput("t6_byp_slot1", 64'(issue_inst[63:32]), 64'hBBBB_0002);
    idle();
    #2;
    checkOutput("t6_byp_count", 64'(count), 64'd1);
    checkOutput("t6_byp_slot0", 64'(issue_inst[31:0]), 64'hBBBB_0002);
    checkOutput("t6_byp_pc0", 64'(issue_pc[31:0]), 64'h3004);
    applyStimulus(1'b0, 0, 32'h0, 64'h0, 1, 1'b0);
`else
    applyStimulus(1'b1, 2, 32'h0000_3000, {32'hBBBB_0002, 32'hAAAA_0001}, 0, 1'b0);
    #2;
    checkOutput("t6_same_valid", 64'(issue_valid), 64'd0);
    idle();
    #2;
    checkOutput("t6_next_valid", 64'(issue_valid), 64'h3);
    checkOutput("t6_next_count", 64'(count), 64'd2);
    checkOutput("t6_next_slot0", 64'(issue_inst[31:0]), 64'hAAAA_0001);
    applyStimulus(1'b0, 0, 32'h0, 64'h0, 2, 1'b0);
`endif
    idle();
    idle();
    #2;
    checkOutput("final_empty", 64'(empty), 64'd1);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
